// File: rtl/vx_hpdcache_mem_req_arbiter.sv
// Merges HPDcache read/write-address/write-data into one Vortex request stream
// and synthesises write acks locally. Option: VX_HPDC_RD_PRIO_EN (strict read priority).
module vx_hpdcache_mem_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4,
  parameter int WACK_DEPTH = 4,
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic [ID_WIDTH-1:0]   rd_req_id,
  input  logic                  wa_valid,
  output logic                  wa_ready,
  input  logic [ADDR_WIDTH-1:0] wa_addr,
  input  logic [ID_WIDTH-1:0]   wa_id,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,
  input  logic [BE_WIDTH-1:0]   wd_be,
  output logic                  wr_rsp_valid,
  input  logic                  wr_rsp_ready,
  output logic [ID_WIDTH-1:0]   wr_rsp_id,
  output logic                  out_req_valid,
  input  logic                  out_req_ready,
  output logic                  out_req_rw,
  output logic [ADDR_WIDTH-1:0] out_req_addr,
  output logic [DATA_WIDTH-1:0] out_req_data,
  output logic [BE_WIDTH-1:0]   out_req_byteen,
  output logic [ID_WIDTH-1:0]   out_req_tag
);

  localparam int PW = $clog2(WACK_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(WACK_DEPTH);

  logic                  wa_vq, wa_vd;
  logic [ADDR_WIDTH-1:0] wa_addr_q, wa_addr_d;
  logic [ID_WIDTH-1:0]   wa_id_q, wa_id_d;
  logic                  wd_vq, wd_vd;
  logic [DATA_WIDTH-1:0] wd_data_q, wd_data_d;
  logic [BE_WIDTH-1:0]   wd_be_q, wd_be_d;

  logic                  out_vq, out_vd;
  logic                  out_rw_q, out_rw_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [BE_WIDTH-1:0]   out_be_q, out_be_d;
  logic [ID_WIDTH-1:0]   out_tag_q, out_tag_d;

  logic [ID_WIDTH-1:0]   ack_mem_q [WACK_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  load_slot;
  logic                  rd_win;
  logic                  rd_load;
  logic                  wr_load;
  logic                  wr_cand;
  logic                  push;
  logic                  pop;
  logic [CW:0]           credits;

  assign load_slot = !out_vq || out_req_ready;
  assign credits   = {1'b0, cnt_q}
                   + {{CW{1'b0}}, out_vq && out_rw_q};
  assign wr_cand   = wa_vq && wd_vq && (credits < DEPTH_C);

`ifdef VX_HPDC_RD_PRIO_EN
  assign rd_win  = 1'b1;
  assign wr_load = load_slot && wr_cand && !rd_req_valid;
`else
  logic rr_q, rr_d;

  assign rd_win  = !(wr_cand && rr_q);
  assign wr_load = load_slot && wr_cand
                && (rr_q || !rd_req_valid);

  // rr_q=1 means the write class is favoured next
  always_comb begin
    rr_d = rr_q;
    if (rd_load) rr_d = 1'b1;
    if (wr_load) rr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rr_q <= 1'b0;
    else          rr_q <= rr_d;
  end
`endif

  assign rd_req_ready = load_slot && rd_win;
  assign rd_load      = rd_req_valid && rd_req_ready;
  assign wa_ready     = !wa_vq || wr_load;
  assign wd_ready     = !wd_vq || wr_load;

  assign push         = out_vq && out_req_ready && out_rw_q;
  assign wr_rsp_valid = (cnt_q != '0);
  assign pop          = wr_rsp_valid && wr_rsp_ready;
  assign wr_rsp_id    = wr_rsp_valid ? ack_mem_q[rptr_q] : '0;

  assign out_req_valid  = out_vq;
  assign out_req_rw     = out_rw_q;
  assign out_req_addr   = out_addr_q;
  assign out_req_data   = out_data_q;
  assign out_req_byteen = out_be_q;
  assign out_req_tag    = out_tag_q;

  always_comb begin
    wa_vd     = wa_vq;
    wa_addr_d = wa_addr_q;
    wa_id_d   = wa_id_q;
    wd_vd     = wd_vq;
    wd_data_d = wd_data_q;
    wd_be_d   = wd_be_q;
    if (wr_load) begin
      wa_vd = 1'b0;
      wd_vd = 1'b0;
    end
    if (wa_valid && wa_ready) begin
      wa_vd     = 1'b1;
      wa_addr_d = wa_addr;
      wa_id_d   = wa_id;
    end
    if (wd_valid && wd_ready) begin
      wd_vd     = 1'b1;
      wd_data_d = wd_data;
      wd_be_d   = wd_be;
    end
  end

  always_comb begin
    out_vd     = out_vq;
    out_rw_d   = out_rw_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_be_d   = out_be_q;
    out_tag_d  = out_tag_q;
    if (load_slot) begin
      unique case (1'b1)
        rd_load: begin
          out_vd     = 1'b1;
          out_rw_d   = 1'b0;
          out_addr_d = rd_req_addr;
          out_data_d = '0;
          out_be_d   = '1;
          out_tag_d  = rd_req_id;
        end
        wr_load: begin
          out_vd     = 1'b1;
          out_rw_d   = 1'b1;
          out_addr_d = wa_addr_q;
          out_data_d = wd_data_q;
          out_be_d   = wd_be_q;
          out_tag_d  = wa_id_q;
        end
        default: out_vd = 1'b0;
      endcase
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wa_vq      <= 1'b0;
      wa_addr_q  <= '0;
      wa_id_q    <= '0;
      wd_vq      <= 1'b0;
      wd_data_q  <= '0;
      wd_be_q    <= '0;
      out_vq     <= 1'b0;
      out_rw_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_be_q   <= '0;
      out_tag_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      wa_vq      <= wa_vd;
      wa_addr_q  <= wa_addr_d;
      wa_id_q    <= wa_id_d;
      wd_vq      <= wd_vd;
      wd_data_q  <= wd_data_d;
      wd_be_q    <= wd_be_d;
      out_vq     <= out_vd;
      out_rw_q   <= out_rw_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_be_q   <= out_be_d;
      out_tag_q  <= out_tag_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Ack storage needs no reset; wr_rsp_id is gated by occupancy
  always_ff @(posedge clk) begin
    if (push) ack_mem_q[wptr_q] <= out_tag_q;
  end

endmodule

// File: tb/tb_vx_hpdcache_mem_req_arbiter.sv
// Self-checking bench for vx_hpdcache_mem_req_arbiter: directed scenarios
// plus randomized traffic against a queue-based scoreboard.
module tb_vx_hpdcache_mem_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 512;
  localparam int IW = 4;
  localparam int BW = DW / 8;
  localparam int D  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic [IW-1:0] rd_req_id;
  logic          wa_valid, wa_ready;
  logic [AW-1:0] wa_addr;
  logic [IW-1:0] wa_id;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic [BW-1:0] wd_be;
  logic          wr_rsp_valid, wr_rsp_ready;
  logic [IW-1:0] wr_rsp_id;
  logic          out_req_valid, out_req_ready, out_req_rw;
  logic [AW-1:0] out_req_addr;
  logic [DW-1:0] out_req_data;
  logic [BW-1:0] out_req_byteen;
  logic [IW-1:0] out_req_tag;

  vx_hpdcache_mem_req_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ID_WIDTH(IW), .WACK_DEPTH(D)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_id(rd_req_id),
    .wa_valid(wa_valid), .wa_ready(wa_ready),
    .wa_addr(wa_addr), .wa_id(wa_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready),
    .wd_data(wd_data), .wd_be(wd_be),
    .wr_rsp_valid(wr_rsp_valid), .wr_rsp_ready(wr_rsp_ready),
    .wr_rsp_id(wr_rsp_id),
    .out_req_valid(out_req_valid), .out_req_ready(out_req_ready),
    .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
    .out_req_data(out_req_data), .out_req_byteen(out_req_byteen),
    .out_req_tag(out_req_tag)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_fire_cnt = 0;
  bit chk_en = 1'b0;

  logic [AW+IW-1:0] rd_q[$];
  logic [AW+IW-1:0] wa_q[$];
  logic [DW+BW-1:0] wd_q[$];
  logic [IW-1:0]    ack_q[$];

  logic [AW+IW-1:0] rexp, wexp;
  logic [DW+BW-1:0] dexp;
  logic [IW-1:0]    aexp;
  logic             prev_stall = 1'b0;
  logic [1+AW+DW+BW+IW-1:0] prev_vec;
  logic [1+AW+DW+BW+IW-1:0] cur_vec;
  logic             wr_fire_now;

  // Scoreboard: events seen here take effect at the next rising edge
  always @(negedge clk) begin
    if (reset_n && out_req_valid && out_req_ready && out_req_rw)
      wr_fire_cnt++;
    if (reset_n && chk_en) begin
      total_cnt++;
      if (wr_rsp_valid !== (ack_q.size() != 0))
        $display("FAIL rsp_valid got %b exp %b", wr_rsp_valid, ack_q.size() != 0);
      else pass_cnt++;
      total_cnt++;
      if (ack_q.size() + int'(out_req_valid && out_req_rw) > D)
        $display("FAIL credit_limit got %0d exp <= %0d",
                 ack_q.size() + int'(out_req_valid && out_req_rw), D);
      else pass_cnt++;
      cur_vec = {out_req_rw, out_req_addr, out_req_data, out_req_byteen, out_req_tag};
      if (prev_stall) begin
        total_cnt++;
        if (out_req_valid !== 1'b1 || cur_vec !== prev_vec)
          $display("FAIL stall_stable got v=%b tag=%h exp v=1 tag=%h",
                   out_req_valid, out_req_tag, prev_vec[IW-1:0]);
        else pass_cnt++;
      end
      prev_stall = out_req_valid && !out_req_ready;
      prev_vec   = cur_vec;
      wr_fire_now = 1'b0;
      if (out_req_valid && out_req_ready) begin
        total_cnt++;
        if (!out_req_rw) begin
          if (rd_q.size() == 0)
            $display("FAIL rd_out got unexpected read tag %h exp none", out_req_tag);
          else begin
            rexp = rd_q.pop_front();
            if ({out_req_addr, out_req_tag} !== rexp
                || out_req_data !== '0 || out_req_byteen !== '1)
              $display("FAIL rd_out got %h/%h exp %h", out_req_addr, out_req_tag, rexp);
            else pass_cnt++;
          end
        end else begin
          if (wa_q.size() == 0 || wd_q.size() == 0)
            $display("FAIL wr_out got unexpected write tag %h exp none", out_req_tag);
          else begin
            wexp = wa_q.pop_front();
            dexp = wd_q.pop_front();
            if ({out_req_addr, out_req_tag} !== wexp
                || {out_req_data, out_req_byteen} !== dexp)
              $display("FAIL wr_out got %h/%h exp %h", out_req_addr, out_req_tag, wexp);
            else pass_cnt++;
            wr_fire_now = 1'b1;
          end
        end
      end
      if (wr_rsp_valid && wr_rsp_ready) begin
        total_cnt++;
        if (ack_q.size() == 0)
          $display("FAIL ack_id got unexpected %h exp none", wr_rsp_id);
        else begin
          aexp = ack_q.pop_front();
          if (wr_rsp_id !== aexp)
            $display("FAIL ack_id got %h exp %h", wr_rsp_id, aexp);
          else pass_cnt++;
        end
      end
      if (wr_fire_now) ack_q.push_back(wexp[IW-1:0]);
      if (rd_req_valid && rd_req_ready) rd_q.push_back({rd_req_addr, rd_req_id});
      if (wa_valid && wa_ready) wa_q.push_back({wa_addr, wa_id});
      if (wd_valid && wd_ready) wd_q.push_back({wd_data, wd_be});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_id = '0;
    wa_valid = 1'b0; wa_addr = '0; wa_id = '0;
    wd_valid = 1'b0; wd_data = '0; wd_be = '0;
    wr_rsp_ready = 1'b0; out_req_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    wr_fire_cnt = 0;
    reset_n = 1'b1;
  endtask

  task automatic feed_writes(input int n, input int cycles);
    int k = 0;
    for (int c = 0; c < cycles; c++) begin
      wa_valid = (k < n);
      wd_valid = (k < n);
      wa_id    = IW'(k);
      wa_addr  = 32'h4000 + AW'(k * 64);
      wd_data  = DW'(k + 1);
      wd_be    = '1;
      #1;
      if (wa_valid && wa_ready && wd_ready) k++;
      tick();
    end
    wa_valid = 1'b0;
    wd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    total_cnt++;
    if ({out_req_valid, wr_rsp_valid, wa_ready, wd_ready, rd_req_ready} !== 5'b00111)
      $display("FAIL reset_ctrl got %b exp 00111",
               {out_req_valid, wr_rsp_valid, wa_ready, wd_ready, rd_req_ready});
    else pass_cnt++;
    total_cnt++;
    if ({out_req_rw, out_req_addr, out_req_data, out_req_byteen, out_req_tag, wr_rsp_id} !== '0)
      $display("FAIL reset_fields got addr=%h tag=%h rsp_id=%h exp 0",
               out_req_addr, out_req_tag, wr_rsp_id);
    else pass_cnt++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    out_req_ready = 1'b1;
    rd_req_valid = 1'b1; rd_req_addr = 32'h1000; rd_req_id = 4'd3;
    #1;
    total_cnt++;
    if (rd_req_ready !== 1'b1) $display("FAIL rd_ready got %b exp 1", rd_req_ready);
    else pass_cnt++;
    tick();
    rd_req_valid = 1'b0;
    #1;
    total_cnt++;
    if (out_req_valid !== 1'b1 || out_req_rw !== 1'b0 || out_req_addr !== 32'h1000
        || out_req_tag !== 4'd3 || out_req_byteen !== '1 || out_req_data !== '0)
      $display("FAIL single_read got v=%b rw=%b a=%h t=%h exp 1/0/1000/3",
               out_req_valid, out_req_rw, out_req_addr, out_req_tag);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_req_valid !== 1'b0) $display("FAIL read_once got %b exp 0", out_req_valid);
    else pass_cnt++;
  endtask

  task automatic test_split_write();
    logic [DW-1:0] d;
    logic [BW-1:0] b;
    d = {(DW/8){8'hAB}};
    b = {(BW/8){8'h0F}};
    do_reset();
    out_req_ready = 1'b1;
    wr_rsp_ready = 1'b1;
    wa_valid = 1'b1; wa_addr = 32'h2040; wa_id = 4'd5;
    tick();
    wa_valid = 1'b0;
    tick();
    wd_valid = 1'b1; wd_data = d; wd_be = b;
    #1;
    total_cnt++;
    if (out_req_valid !== 1'b0 || wd_ready !== 1'b1 || wa_ready !== 1'b0)
      $display("FAIL wa_only got v=%b wdr=%b war=%b exp 0/1/0",
               out_req_valid, wd_ready, wa_ready);
    else pass_cnt++;
    tick();
    wd_valid = 1'b0;
    #1;
    total_cnt++;
    if (out_req_valid !== 1'b0) $display("FAIL wr_lat1 got %b exp 0", out_req_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_req_valid !== 1'b1 || out_req_rw !== 1'b1 || out_req_addr !== 32'h2040
        || out_req_tag !== 4'd5 || out_req_data !== d || out_req_byteen !== b)
      $display("FAIL split_write got v=%b rw=%b a=%h t=%h exp 1/1/2040/5",
               out_req_valid, out_req_rw, out_req_addr, out_req_tag);
    else pass_cnt++;
    total_cnt++;
    if (wr_rsp_valid !== 1'b0) $display("FAIL early_ack got %b exp 0", wr_rsp_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_req_valid !== 1'b0 || wr_rsp_valid !== 1'b1 || wr_rsp_id !== 4'd5)
      $display("FAIL write_ack got v=%b rsp=%b id=%h exp 0/1/5",
               out_req_valid, wr_rsp_valid, wr_rsp_id);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (wr_rsp_valid !== 1'b0) $display("FAIL ack_pop got %b exp 0", wr_rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    logic exp_rw;
    do_reset();
    out_req_ready = 1'b1; wr_rsp_ready = 1'b1;
    rd_req_valid = 1'b1; wa_valid = 1'b1; wd_valid = 1'b1;
    wd_be = '1;
    for (int i = 0; i < 8; i++) begin
      rd_req_id = IW'(i); wa_id = IW'(i + 8);
      tick();
`ifdef VX_HPDC_RD_PRIO_EN
      exp_rw = 1'b0;
`else
      exp_rw = (i % 2 == 1);
`endif
      total_cnt++;
      if (out_req_valid !== 1'b1 || out_req_rw !== exp_rw)
        $display("FAIL contention[%0d] got v=%b rw=%b exp 1/%b",
                 i, out_req_valid, out_req_rw, exp_rw);
      else pass_cnt++;
    end
    idle_inputs();
  endtask

  task automatic test_ack_full();
    do_reset();
    out_req_ready = 1'b1;
    wr_rsp_ready = 1'b0;
    feed_writes(5, 20);
    total_cnt++;
    if (wr_fire_cnt !== 4 || out_req_valid !== 1'b0)
      $display("FAIL ack_full got fires=%0d v=%b exp 4/0", wr_fire_cnt, out_req_valid);
    else pass_cnt++;
    total_cnt++;
    if (wr_rsp_valid !== 1'b1 || wr_rsp_id !== 4'd0)
      $display("FAIL ack_head got %b/%h exp 1/0", wr_rsp_valid, wr_rsp_id);
    else pass_cnt++;
    rd_req_valid = 1'b1; rd_req_addr = 32'h5000; rd_req_id = 4'd9;
    #1;
    total_cnt++;
    if (rd_req_ready !== 1'b1) $display("FAIL rd_at_full got %b exp 1", rd_req_ready);
    else pass_cnt++;
    tick();
    rd_req_valid = 1'b0;
    #1;
    total_cnt++;
    if (out_req_valid !== 1'b1 || out_req_rw !== 1'b0 || out_req_tag !== 4'd9)
      $display("FAIL rd_pass_full got v=%b rw=%b t=%h exp 1/0/9",
               out_req_valid, out_req_rw, out_req_tag);
    else pass_cnt++;
    tick();
    wr_rsp_ready = 1'b1;
    tick();
    wr_rsp_ready = 1'b0;
    #1;
    total_cnt++;
    if (out_req_valid !== 1'b0 || wr_fire_cnt !== 4)
      $display("FAIL fifth_early got v=%b fires=%0d exp 0/4", out_req_valid, wr_fire_cnt);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_req_valid !== 1'b1 || out_req_rw !== 1'b1 || out_req_tag !== 4'd4)
      $display("FAIL fifth_issue got v=%b rw=%b t=%h exp 1/1/4",
               out_req_valid, out_req_rw, out_req_tag);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_req_ready = 1'b0;
    rd_req_valid = 1'b1; rd_req_addr = 32'h3000; rd_req_id = 4'd7;
    tick();
    rd_req_addr = 32'h3004; rd_req_id = 4'd8;
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++;
      if (out_req_valid !== 1'b1 || out_req_addr !== 32'h3000
          || out_req_tag !== 4'd7 || rd_req_ready !== 1'b0)
        $display("FAIL bp_hold[%0d] got v=%b a=%h t=%h rdy=%b exp 1/3000/7/0",
                 i, out_req_valid, out_req_addr, out_req_tag, rd_req_ready);
      else pass_cnt++;
      tick();
    end
    out_req_ready = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    #1;
    total_cnt++;
    if (out_req_valid !== 1'b1 || out_req_addr !== 32'h3004 || out_req_tag !== 4'd8)
      $display("FAIL bp_next got v=%b a=%h t=%h exp 1/3004/8",
               out_req_valid, out_req_addr, out_req_tag);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_req_valid !== 1'b0) $display("FAIL bp_nodup got %b exp 0", out_req_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_req_ready = 1'b1;
    wr_rsp_ready = 1'b0;
    feed_writes(2, 8);
    out_req_ready = 1'b0;
    feed_writes(1, 6);
    total_cnt++;
    if (wr_rsp_valid !== 1'b1 || out_req_valid !== 1'b1 || out_req_rw !== 1'b1)
      $display("FAIL pre_reset got rsp=%b v=%b rw=%b exp 1/1/1",
               wr_rsp_valid, out_req_valid, out_req_rw);
    else pass_cnt++;
    reset_n = 1'b0;
    tick();
    total_cnt++;
    if ({out_req_valid, wr_rsp_valid, wa_ready, wd_ready, rd_req_ready} !== 5'b00111
        || out_req_addr !== '0 || out_req_tag !== '0)
      $display("FAIL mid_reset got %b exp 00111",
               {out_req_valid, wr_rsp_valid, wa_ready, wd_ready, rd_req_ready});
    else pass_cnt++;
    reset_n = 1'b1;
    tick();
    total_cnt++;
    if (wr_rsp_valid !== 1'b0 || out_req_valid !== 1'b0)
      $display("FAIL post_reset got rsp=%b v=%b exp 0/0", wr_rsp_valid, out_req_valid);
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit rd_acc, wa_acc, wd_acc, drain;
    int wa_n, wd_n;
    rd_acc = 0; wa_acc = 0; wd_acc = 0;
    wa_n = 0; wd_n = 0;
    do_reset();
    rd_q.delete(); wa_q.delete(); wd_q.delete(); ack_q.delete();
    prev_stall = 1'b0;
    chk_en = 1'b1;
    for (int c = 0; c < 1600; c++) begin
      drain = (c >= 1500);
      if (rd_acc) rd_req_valid = 1'b0;
      if (!rd_req_valid && !drain && $urandom_range(0, 99) < 60) begin
        rd_req_valid = 1'b1;
        rd_req_addr = $urandom;
        rd_req_id = IW'($urandom);
      end
      if (wa_acc) begin wa_valid = 1'b0; wa_n++; end
      if (wd_acc) begin wd_valid = 1'b0; wd_n++; end
      if (!wa_valid && (drain ? (wa_n < wd_n) : ($urandom_range(0, 99) < 50))) begin
        wa_valid = 1'b1;
        wa_addr = $urandom;
        wa_id = IW'($urandom);
      end
      if (!wd_valid && (drain ? (wd_n < wa_n) : ($urandom_range(0, 99) < 50))) begin
        wd_valid = 1'b1;
        for (int i = 0; i < DW / 32; i++) wd_data[i*32 +: 32] = $urandom;
        for (int i = 0; i < BW / 32; i++) wd_be[i*32 +: 32] = $urandom;
      end
      out_req_ready = drain ? 1'b1 : ($urandom_range(0, 99) < 70);
      wr_rsp_ready  = drain ? 1'b1 : ($urandom_range(0, 99) < 40);
      #1;
      rd_acc = rd_req_valid && rd_req_ready;
      wa_acc = wa_valid && wa_ready;
      wd_acc = wd_valid && wd_ready;
      tick();
    end
    chk_en = 1'b0;
    total_cnt++;
    if (rd_q.size() + wa_q.size() + wd_q.size() + ack_q.size() != 0)
      $display("FAIL rand_drain got rd=%0d wa=%0d wd=%0d ack=%0d exp 0",
               rd_q.size(), wa_q.size(), wd_q.size(), ack_q.size());
    else pass_cnt++;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_split_write();
    test_contention();
    test_ack_full();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
